uart_rx: RTL and testbench

//   Unbuffered UART receiver, the receive-side counterpart of uart_tx.

---
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Unbuffered 8N1-style UART receiver: two-flop synchroniser, mid-bit sampling,
// stop-bit check, single-cycle valid / frame_err strobes. DATA_BITS must be >= 2.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int DATA_BITS      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int BW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] HALF     = BW'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [BW-1:0] LAST     = BW'(CLOCKS_PER_BIT - 1);
    localparam logic [NW-1:0] LAST_BIT = NW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [BW-1:0]        r_baud_cnt;
    logic [NW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 w_rx_s;

    assign w_rx_s = r_sync2;

    // Flow: strobes default low every cycle; each state leaves with baud_cnt cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (!w_rx_s) r_state <= S_START;
                end
                S_START: begin
                    if (r_baud_cnt == HALF) begin
                        r_baud_cnt <= '0;
                        r_state    <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (r_baud_cnt == LAST) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + NW'(1);
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                S_STOP: begin
                    if (r_baud_cnt == LAST) begin
                        r_baud_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    // A break or stuck-low line must release before a new start is hunted.
                    r_baud_cnt <= '0;
                    if (w_rx_s) r_state <= S_IDLE;
                end
                default: begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged frames feed a scoreboard queue that a
// negedge monitor drains on every valid / frame_err strobe, checking data and edge timing.
module tb_uart_rx;

    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int LAT = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic [DB-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          busy;
    logic [2:0]    dbg_state;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    logic [7:0] last_data = 8'h00;

    // Entry: {kind (1 = frame_err), data[7:0], edge[31:0]}
    logic [40:0] exp_q[$];

    uart_rx #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Caller is #1 after a posedge; the next posedge is E0 for this frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        int e0;
        e0 = cyc + 1;
        if (stop_val) begin
            exp_q.push_back({1'b0, d, 32'(e0 + LAT)});
            last_data = d;
        end else begin
            exp_q.push_back({1'b1, last_data, 32'(e0 + LAT)});
        end
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = stop_val;
        tick(CPB);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid && frame_err) begin
                compared++;
                mismatched++;
                $display("FAIL both_strobes: valid=%b frame_err=%b at edge %0d", valid, frame_err, cyc);
            end else if (valid || frame_err) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_strobe: valid=%b frame_err=%b data=%0h at edge %0d",
                             valid, frame_err, data, cyc);
                end else begin
                    logic [40:0] e;
                    e = exp_q.pop_front();
                    if (frame_err !== e[40] || data !== e[39:32] || cyc != int'(e[31:0])) begin
                        mismatched++;
                        $display("FAIL strobe: got err=%b data=%0h edge=%0d expected err=%b data=%0h edge=%0d",
                                 frame_err, data, cyc, e[40], e[39:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        int e0;
        int guard;
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        check("reset_data", 32'(data), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick(3);

        send_frame(8'hA5, 1'b1);
        tick(4);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        tick(4);

        // One-clock glitch: start must be rejected at mid-bit.
        rx = 1'b0;
        e0 = cyc + 1;
        tick(1);
        rx = 1'b1;
        tick(2);
        check("glitch_busy_rise", 32'(busy), 32'h1);
        tick(3);
        check("glitch_idle_by_half_plus4", 32'(busy), 32'h0);
        check("glitch_edge", 32'(cyc), 32'(e0 + 5));
        tick(8);

        send_frame(8'h3C, 1'b0);
        tick(20);
        check("break_busy_held", 32'(busy), 32'h1);
        check("break_data_held", 32'(data), 32'h55);
        rx = 1'b1;
        tick(4);
        check("break_released", 32'(busy), 32'h0);

        // Abort a frame partway through the data bits.
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(6);
        check("midframe_state_data", 32'(dbg_state), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        last_data = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        send_frame(8'h81, 1'b1);
        tick(4);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            tick(1);
            guard++;
        end
        while (exp_q.size() != 0) begin
            logic [40:0] e;
            e = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL missing_strobe: expected err=%b data=%0h edge=%0d",
                     e[40], e[39:32], e[31:0]);
        end
        check("final_data", 32'(data), 32'h81);
        check("final_idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
